// File: rtl/image_upscaler_12bit_if.sv
// rtl/image_upscaler_12bit_if.sv - pixel stream and status bundle for the 12-bit image upscaler
interface image_upscaler_12bit_if;
    logic [11:0] pixel_in;
    logic        valid_in;
    logic        ready_in;
    logic [11:0] pixel_out;
    logic        valid_out;
    logic        ready_out;
    logic        frame_done;
    logic        pad_err;

    modport master (
        output pixel_in, valid_in, ready_out,
        input  ready_in, pixel_out, valid_out, frame_done, pad_err
    );

    modport slave (
        input  pixel_in, valid_in, ready_out,
        output ready_in, pixel_out, valid_out, frame_done, pad_err
    );
endinterface

// File: rtl/image_upscaler_12bit.sv
// rtl/image_upscaler_12bit.sv - nearest-neighbour upscaler from a zero-padded square grid
module image_upscaler_12bit #(
    parameter int OUT_WIDTH  = 1280,
    parameter int OUT_HEIGHT = 960,
    parameter int IMG_DIM    = 32,
    parameter int PAD_DIM    = 34
) (
    input  logic                        clk,
    input  logic                        rst,
    image_upscaler_12bit_if.slave       bus
);
    localparam int IMG_LOG2 = $clog2(IMG_DIM);
    localparam int X_SCALE  = OUT_WIDTH >> IMG_LOG2;
    localparam int Y_SCALE  = OUT_HEIGHT >> IMG_LOG2;
    localparam int PW       = $clog2(PAD_DIM);
    localparam int AW       = (IMG_LOG2 > 0) ? IMG_LOG2 : 1;
    localparam int XW       = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;
    localparam int YW       = (Y_SCALE > 1) ? $clog2(Y_SCALE) : 1;
    localparam int DEPTH    = 1 << (2 * AW);

    localparam logic [PW-1:0] P_LAST = PW'(PAD_DIM - 1);
    localparam logic [PW-1:0] IMG_HI = PW'(IMG_DIM);
    localparam logic [AW-1:0] C_LAST = AW'(IMG_DIM - 1);
    localparam logic [XW-1:0] X_LAST = XW'(X_SCALE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SCALE - 1);

    localparam logic [0:0] ST_RECEIVE = 1'b0;
    localparam logic [0:0] ST_OUTPUT  = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] in_row, in_col;
    logic [AW-1:0] src_row, src_col, nx_src_row, nx_src_col;
    logic [XW-1:0] rep_x, nx_rep_x;
    logic [YW-1:0] rep_y, nx_rep_y;
    logic [11:0]   pix_q;
    logic          done_q;
    logic          pad_q;

    logic [11:0]     mem [0:DEPTH-1];
    logic [2*AW-1:0] wr_addr, rd_addr;

    logic in_xfer, out_xfer, interior, last_in, last_out;

    assign in_xfer  = bus.valid_in && (state == ST_RECEIVE);
    assign out_xfer = bus.ready_out && (state == ST_OUTPUT);
    assign interior = (in_row != '0) && (in_row <= IMG_HI) &&
                      (in_col != '0) && (in_col <= IMG_HI);
    assign last_in  = (in_row == P_LAST) && (in_col == P_LAST);
    assign last_out = (rep_x == X_LAST) && (src_col == C_LAST) &&
                      (rep_y == Y_LAST) && (src_row == C_LAST);

    assign wr_addr = {AW'(in_row - 1'b1), AW'(in_col - 1'b1)};
    // The grid is a power of two, so the sample address is a plain concatenation.
    assign rd_addr = (state == ST_OUTPUT) ? {nx_src_row, nx_src_col} : '0;

    always_comb begin
        nx_rep_x   = rep_x;
        nx_src_col = src_col;
        nx_rep_y   = rep_y;
        nx_src_row = src_row;
        if (rep_x == X_LAST) begin
            nx_rep_x = '0;
            if (src_col == C_LAST) begin
                nx_src_col = '0;
                if (rep_y == Y_LAST) begin
                    nx_rep_y   = '0;
                    nx_src_row = (src_row == C_LAST) ? '0 : src_row + 1'b1;
                end else begin
                    nx_rep_y = rep_y + 1'b1;
                end
            end else begin
                nx_src_col = src_col + 1'b1;
            end
        end else begin
            nx_rep_x = rep_x + 1'b1;
        end
    end

    // Sample store has no reset; contents only matter after a full frame is written.
    always_ff @(posedge clk) begin
        if (in_xfer && interior) begin
            mem[wr_addr] <= bus.pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RECEIVE;
            in_row  <= '0;
            in_col  <= '0;
            src_row <= '0;
            src_col <= '0;
            rep_x   <= '0;
            rep_y   <= '0;
            pix_q   <= '0;
            done_q  <= 1'b0;
            pad_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (in_xfer) begin
                if (!interior && (bus.pixel_in != '0)) begin
                    pad_q <= 1'b1;
                end
                if (last_in) begin
                    in_row <= '0;
                    in_col <= '0;
                    state  <= ST_OUTPUT;
                    pix_q  <= mem[rd_addr];
                end else if (in_col == P_LAST) begin
                    in_col <= '0;
                    in_row <= in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end
            // Counter wrap at the final pixel lands every counter back on zero.
            if (out_xfer) begin
                rep_x   <= nx_rep_x;
                src_col <= nx_src_col;
                rep_y   <= nx_rep_y;
                src_row <= nx_src_row;
                if (last_out) begin
                    state  <= ST_RECEIVE;
                    done_q <= 1'b1;
                end else begin
                    pix_q <= mem[rd_addr];
                end
            end
        end
    end

    assign bus.ready_in   = (state == ST_RECEIVE);
    assign bus.valid_out  = (state == ST_OUTPUT);
    assign bus.pixel_out  = pix_q;
    assign bus.frame_done = done_q;
    assign bus.pad_err    = pad_q;
endmodule

// File: doc/image_upscaler_12bit.md
IMAGE_UPSCALER_12BIT -- requirements
Module: image_upscaler_12bit

Interface
REQ-001 Parameter: OUT_WIDTH, default 1280, output frame width in pixels.
REQ-002 Parameter: OUT_HEIGHT, default 960, output frame height in lines.
REQ-003 Parameter: IMG_DIM, default 32, sample grid dimension (power of two).
REQ-004 Parameter: PAD_DIM, default 34, padded input dimension (IMG_DIM+2).
REQ-005 Port: clk  input  1  single clock, all logic on rising edge.
REQ-006 Port: rst  input  1  synchronous, active-high reset.
REQ-007 Port: pixel_in  input  12  padded-image pixel, raster order.
REQ-008 Port: valid_in  input  1  pixel_in valid.
REQ-009 Port: ready_in  output  1  block accepts input; transfer = valid_in && ready_in.
REQ-010 Port: pixel_out  output  12  upscaled pixel, registered.
REQ-011 Port: valid_out  output  1  pixel_out valid, registered.
REQ-012 Port: ready_out  input  1  downstream accepts; transfer = valid_out && ready_out.
REQ-013 Port: frame_done  output  1  one-cycle pulse after the last output pixel transfers.
REQ-014 Port: pad_err  output  1  sticky flag: nonzero border pixel received.

Function
REQ-015 X_SCALE = OUT_WIDTH >> log2(IMG_DIM) (40) and Y_SCALE = OUT_HEIGHT >> log2(IMG_DIM) (30), derived by shift; no divider or modulo logic.
REQ-016 Two states: RECEIVE (ready_in=1, valid_out=0) and OUTPUT (ready_in=0, valid_out=1).
REQ-017 RECEIVE: each input transfer advances in_col 0..PAD_DIM-1, wrapping to 0 with in_row+1; in_row 0..PAD_DIM-1.
REQ-018 Input at in_row in 1..IMG_DIM and in_col in 1..IMG_DIM is written to mem[in_row-1][in_col-1]; all other positions are border and are not stored.
REQ-019 A border transfer with pixel_in != 0 sets pad_err on the next edge; pad_err stays 1 until rst.
REQ-020 Transfer of in_row=PAD_DIM-1, in_col=PAD_DIM-1 moves the state to OUTPUT on the same edge: ready_in=0, valid_out=1, pixel_out=mem[0][0] on the next cycle.
REQ-021 valid_in while ready_in=0 is ignored; no counter or memory change.
REQ-022 OUTPUT: counters rep_x 0..X_SCALE-1, src_col 0..IMG_DIM-1, rep_y 0..Y_SCALE-1, src_row 0..IMG_DIM-1 advance only on an output transfer.
REQ-023 Each output pixel equals mem[src_row][src_col] (nearest-neighbour): every sample repeats X_SCALE times per line and each line repeats Y_SCALE times.
REQ-024 On an output transfer, pixel_out and the counters update on the same edge to the next position; with ready_out=0, pixel_out, valid_out and the counters hold.
REQ-025 Counter wrap order: rep_x, then src_col, then rep_y, then src_row.
REQ-026 The transfer of the last pixel (src_row=IMG_DIM-1, src_col=IMG_DIM-1, rep_x=X_SCALE-1, rep_y=Y_SCALE-1) returns the state to RECEIVE, clears valid_out, sets ready_in and clears all counters on the same edge.
REQ-027 frame_done=1 for exactly the cycle after the last-pixel transfer.
REQ-028 Exactly OUT_WIDTH*OUT_HEIGHT (1,228,800) output transfers occur per received padded frame.
REQ-029 Memory is 1024x12, with no reset and a single write port. Reads use a registered output that feeds pixel_out.

Reset
REQ-030 rst=1 at a clock edge gives: state RECEIVE, ready_in=1, valid_out=0, pixel_out=0, frame_done=0, pad_err=0, all counters 0.
REQ-031 Reset in any state aborts the frame. The next accepted input pixel is treated as padded position (0,0).
REQ-032 Memory contents are undefined after reset, and no output is produced until a full padded frame has been received.

Verification
REQ-033 Zero border and interior pixel (r,c) = r*32+c; stream 1156 pixels -> 1,228,800 outputs, with output (x,y) = (y/30)*32+(x/40), pad_err=0, one frame_done.
REQ-034 Border pixel at row 0, col 5 = 12'h001 -> pad_err=1 from the next cycle and held through the whole frame; output data unaffected.
REQ-035 Random ready_out toggling with about 50% duty -> no output pixel dropped or duplicated; pixel_out stable while valid_out=1 and ready_out=0.
REQ-036 valid_in held high during OUTPUT -> ready_in=0 and memory unchanged; the next frame is received correctly after frame_done.
REQ-037 rst pulsed at output transfer 5000 -> next cycle valid_out=0, ready_in=1; a fresh frame then upscales correctly.
REQ-038 Two frames streamed back to back -> the second frame's input is accepted only after frame_done, and its output matches its own data.
